// File: rtl/psum_mem_arbiter.sv
// Arbitrates the single-port psum BRAM between the core accumulate path and the drain engine.
// Optional stall/wait statistics counters are built when PSUM_ARB_STATS_EN is defined.
module psum_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WQ_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] c_wadd,
    input  logic                  c_wren,
    input  logic [DATA_WIDTH-1:0] c_idat,
    output logic                  c_wready,
    input  logic [ADDR_WIDTH-1:0] c_radd,
    input  logic                  c_rden,
    output logic                  c_rready,
    output logic [DATA_WIDTH-1:0] c_odat,
    output logic                  c_oval,
    input  logic [ADDR_WIDTH-1:0] d_radd,
    input  logic                  d_rden,
    output logic                  d_gnt,
    output logic [DATA_WIDTH-1:0] d_odat,
    output logic                  d_oval,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_idat,
    output logic                  mem_wren,
    output logic                  mem_enb,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    output logic [31:0]           stat_cstall,
    output logic [31:0]           stat_dwait
);

    localparam int WQ_AW = $clog2(WQ_DEPTH);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [WQ_AW:0]  WQ_FULL_CNT = (WQ_AW + 1)'(WQ_DEPTH);
    localparam logic [SC_W-1:0] STARVE_TOP  = SC_W'(STARVE_MAX);

    localparam logic [1:0] SEL_IDLE  = 2'd0;
    localparam logic [1:0] SEL_WRITE = 2'd1;
    localparam logic [1:0] SEL_CREAD = 2'd2;
    localparam logic [1:0] SEL_DREAD = 2'd3;

    logic [ADDR_WIDTH-1:0] wq_addr [WQ_DEPTH];
    logic [DATA_WIDTH-1:0] wq_data [WQ_DEPTH];
    logic [WQ_AW:0]        wr_ptr;
    logic [WQ_AW:0]        rd_ptr;
    logic [WQ_AW:0]        wq_count;
    logic                  wq_full;
    logic                  wq_empty;
    logic                  wq_enq;
    logic                  wq_deq;
    logic                  hazard;
    logic [WQ_AW-1:0]      offs;
    logic [1:0]            sel;
    logic [SC_W-1:0]       starve_cnt;
    logic [2:0]            tag_vld;
    logic [2:0]            tag_src;

    assign wq_count = wr_ptr - rd_ptr;
    assign wq_full  = (wq_count == WQ_FULL_CNT);
    assign wq_empty = (wr_ptr == rd_ptr);

    // A read may not bypass any queued write to the same address, including one entering this cycle.
    always_comb begin
        hazard = c_wren && (c_wadd == c_radd);
        offs   = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            offs = WQ_AW'(i) - rd_ptr[WQ_AW-1:0];
            if (({1'b0, offs} < wq_count) && (wq_addr[i] == c_radd)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        sel = SEL_IDLE;
        if (!rst) begin
            if (d_rden && (starve_cnt == STARVE_TOP)) begin
                sel = SEL_DREAD;
            end else if (wq_full) begin
                sel = SEL_WRITE;
            end else if (c_rden && !hazard) begin
                sel = SEL_CREAD;
            end else if (!wq_empty) begin
                sel = SEL_WRITE;
            end else if (d_rden) begin
                sel = SEL_DREAD;
            end
        end
    end

    assign wq_deq   = (sel == SEL_WRITE);
    assign c_rready = (sel == SEL_CREAD);
    assign d_gnt    = (sel == SEL_DREAD);
    assign c_wready = !rst && (!wq_full || wq_deq);
    assign wq_enq   = c_wren && c_wready;

    always_ff @(posedge clk) begin
        if (wq_enq) begin
            wq_addr[wr_ptr[WQ_AW-1:0]] <= c_wadd;
            wq_data[wr_ptr[WQ_AW-1:0]] <= c_idat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (wq_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wq_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (d_gnt || !d_rden) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Address and write data hold their last value on idle cycles; only the enables drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            mem_idat <= '0;
            mem_wren <= 1'b0;
            mem_enb  <= 1'b0;
        end else begin
            mem_enb  <= (sel != SEL_IDLE);
            mem_wren <= (sel == SEL_WRITE);
            case (sel)
                SEL_WRITE: begin
                    mem_addr <= wq_addr[rd_ptr[WQ_AW-1:0]];
                    mem_idat <= wq_data[rd_ptr[WQ_AW-1:0]];
                end
                SEL_CREAD: mem_addr <= c_radd;
                SEL_DREAD: mem_addr <= d_radd;
                default:   ;
            endcase
        end
    end

    // Stage 0 rides with mem_*, stage 1 with mem_odat, stage 2 with the registered return data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_src <= '0;
            c_odat  <= '0;
            d_odat  <= '0;
        end else begin
            tag_vld <= {tag_vld[1:0], (sel == SEL_CREAD) || (sel == SEL_DREAD)};
            tag_src <= {tag_src[1:0], (sel == SEL_DREAD)};
            if (tag_vld[1] && !tag_src[1]) begin
                c_odat <= mem_odat;
            end
            if (tag_vld[1] && tag_src[1]) begin
                d_odat <= mem_odat;
            end
        end
    end

    assign c_oval = tag_vld[2] && !tag_src[2];
    assign d_oval = tag_vld[2] && tag_src[2];

`ifdef PSUM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cstall <= '0;
            stat_dwait  <= '0;
        end else begin
            if (c_rden && !c_rready && (stat_cstall != 32'hFFFF_FFFF)) begin
                stat_cstall <= stat_cstall + 32'd1;
            end
            if (d_rden && !d_gnt && (stat_dwait != 32'hFFFF_FFFF)) begin
                stat_dwait <= stat_dwait + 32'd1;
            end
        end
    end
`else
    assign stat_cstall = '0;
    assign stat_dwait  = '0;
`endif

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed bench for psum_mem_arbiter: table of single reads plus hand sequences for
// hazard, write streaming, full queue, drain starvation and reset.
module tb_psum_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] c_wadd = '0;
    logic        c_wren = 1'b0;
    logic [31:0] c_idat = '0;
    logic        c_wready;
    logic [31:0] c_radd = '0;
    logic        c_rden = 1'b0;
    logic        c_rready;
    logic [31:0] c_odat;
    logic        c_oval;
    logic [31:0] d_radd = '0;
    logic        d_rden = 1'b0;
    logic        d_gnt;
    logic [31:0] d_odat;
    logic        d_oval;
    logic [31:0] mem_addr;
    logic [31:0] mem_idat;
    logic        mem_wren;
    logic        mem_enb;
    logic [31:0] mem_odat = '0;
    logic [31:0] stat_cstall;
    logic [31:0] stat_dwait;

    logic [31:0] bram [256];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PSUM_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct {
        logic        src;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [6];

    psum_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .c_wadd(c_wadd), .c_wren(c_wren), .c_idat(c_idat), .c_wready(c_wready),
        .c_radd(c_radd), .c_rden(c_rden), .c_rready(c_rready), .c_odat(c_odat), .c_oval(c_oval),
        .d_radd(d_radd), .d_rden(d_rden), .d_gnt(d_gnt), .d_odat(d_odat), .d_oval(d_oval),
        .mem_addr(mem_addr), .mem_idat(mem_idat), .mem_wren(mem_wren), .mem_enb(mem_enb),
        .mem_odat(mem_odat), .stat_cstall(stat_cstall), .stat_dwait(stat_dwait)
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_enb) begin
            if (mem_wren) bram[mem_addr[7:0]] <= mem_idat;
            else          mem_odat <= bram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic win();
        @(negedge clk);
    endtask

    task automatic idle_in();
        c_wren = 1'b0;
        c_rden = 1'b0;
        d_rden = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h10, 32'h55};
        vecs[1] = '{1'b0, 32'h11, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h30, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'h31, 32'h0};
        vecs[4] = '{1'b0, 32'hFF, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 32'h00, 32'hA5A5_5A5A};
        for (int i = 0; i < 256; i++) bram[i] = 32'hDEAD_0000 | i;

        // Reset: requests ignored, no handshakes while rst is high.
        win();
        rst = 1'b1; c_rden = 1'b1; c_wren = 1'b1; d_rden = 1'b1;
        #1;
        chk("rst_c_rready", {31'd0, c_rready}, 32'd0);
        chk("rst_c_wready", {31'd0, c_wready}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        win();
        rst = 1'b0; idle_in();
        #1;
        chk("rst_mem_enb", {31'd0, mem_enb}, 32'd0);
        chk("rst_c_oval", {31'd0, c_oval}, 32'd0);
        chk("rst_c_wready_after", {31'd0, c_wready}, 32'd1);
        chk("rst_stat_cstall", stat_cstall, 32'd0);
        chk("rst_stat_dwait", stat_dwait, 32'd0);

        // Isolated reads: grant same cycle, data exactly three cycles later.
        for (int i = 0; i < 6; i++) begin
            win();
            bram[vecs[i].addr[7:0]] = vecs[i].data;
            if (vecs[i].src) begin d_rden = 1'b1; d_radd = vecs[i].addr; end
            else             begin c_rden = 1'b1; c_radd = vecs[i].addr; end
            #1;
            chk($sformatf("vec%0d_gnt", i), {31'd0, vecs[i].src ? d_gnt : c_rready}, 32'd1);
            for (int k = 1; k <= 3; k++) begin
                win();
                idle_in();
                #1;
                if (k < 3) begin
                    chk($sformatf("vec%0d_early_val%0d", i, k), {31'd0, vecs[i].src ? d_oval : c_oval}, 32'd0);
                end else begin
                    chk($sformatf("vec%0d_val", i), {31'd0, vecs[i].src ? d_oval : c_oval}, 32'd1);
                    chk($sformatf("vec%0d_data", i), vecs[i].src ? d_odat : c_odat, vecs[i].data);
                    chk($sformatf("vec%0d_other_val", i), {31'd0, vecs[i].src ? c_oval : d_oval}, 32'd0);
                end
            end
        end

        // Read-after-write hazard on 0x20.
        win();
        c_wren = 1'b1; c_wadd = 32'h20; c_idat = 32'hAB;
        #1 chk("raw_wready", {31'd0, c_wready}, 32'd1);
        win();
        c_wren = 1'b0; c_rden = 1'b1; c_radd = 32'h20;
        #1 chk("raw_blocked", {31'd0, c_rready}, 32'd0);
        win();
        #1;
        chk("raw_mem_wren", {31'd0, mem_wren}, 32'd1);
        chk("raw_mem_addr", mem_addr, 32'h20);
        chk("raw_rready", {31'd0, c_rready}, 32'd1);
        win(); idle_in();
        win();
        #1 chk("raw_early_val", {31'd0, c_oval}, 32'd0);
        win();
        #1;
        chk("raw_oval", {31'd0, c_oval}, 32'd1);
        chk("raw_odat", c_odat, 32'hAB);

        // Five back-to-back writes stream through one per cycle.
        for (int k = 0; k < 8; k++) begin
            win();
            c_wren = (k < 5); c_wadd = 32'h40 + k; c_idat = 32'h100 + k;
            #1;
            if (k < 5) chk($sformatf("stream_wready%0d", k), {31'd0, c_wready}, 32'd1);
            if (k >= 2 && k <= 6) begin
                chk($sformatf("stream_wren%0d", k), {31'd0, mem_wren}, 32'd1);
                chk($sformatf("stream_addr%0d", k), mem_addr, 32'h40 + k - 2);
                chk($sformatf("stream_idat%0d", k), mem_idat, 32'h100 + k - 2);
            end
            if (k == 7) begin
                chk("stream_idle_enb", {31'd0, mem_enb}, 32'd0);
                chk("stream_hold_addr", mem_addr, 32'h44);
            end
        end

        // Drain starvation: fresh reset so statistics start from zero.
        win(); rst = 1'b1; idle_in();
        win(); rst = 1'b0;
        bram[8'h70] = 32'h7777;
        for (int k = 0; k < 10; k++) begin
            win();
            c_rden = 1'b1; c_radd = 32'h10; d_rden = (k < 9); d_radd = 32'h70;
            #1;
            if (k < 8) begin
                chk($sformatf("starve_dgnt%0d", k), {31'd0, d_gnt}, 32'd0);
                chk($sformatf("starve_crdy%0d", k), {31'd0, c_rready}, 32'd1);
            end else if (k == 8) begin
                chk("starve_forced_dgnt", {31'd0, d_gnt}, 32'd1);
                chk("starve_core_stall", {31'd0, c_rready}, 32'd0);
            end else begin
                chk("starve_core_resume", {31'd0, c_rready}, 32'd1);
            end
        end
        win(); idle_in();
        #1;
        chk("stat_dwait", stat_dwait, STATS_ON ? 32'd8 : 32'd0);
        chk("stat_cstall", stat_cstall, STATS_ON ? 32'd1 : 32'd0);
        win();
        #1;
        chk("starve_doval", {31'd0, d_oval}, 32'd1);
        chk("starve_dodat", d_odat, 32'h7777);
        chk("starve_no_coval", {31'd0, c_oval}, 32'd0);
        repeat (4) win();

        // Fill the queue behind core reads, then full queue overrides the read.
        for (int k = 0; k < 5; k++) begin
            win();
            c_wren = 1'b1; c_wadd = 32'h80 + k; c_idat = 32'h800 + k;
            c_rden = 1'b1; c_radd = 32'h90 + k;
            #1;
            chk($sformatf("full_wready%0d", k), {31'd0, c_wready}, 32'd1);
            chk($sformatf("full_rready%0d", k), {31'd0, c_rready}, (k < 4) ? 32'd1 : 32'd0);
        end
        for (int k = 5; k < 11; k++) begin
            win();
            idle_in();
            #1;
            if (k < 10) begin
                chk($sformatf("full_wren%0d", k), {31'd0, mem_wren}, 32'd1);
                chk($sformatf("full_addr%0d", k), mem_addr, 32'h80 + k - 5);
            end else begin
                chk("full_drained", {31'd0, mem_enb}, 32'd0);
            end
        end
        repeat (3) win();

        // Reset with reads in flight and writes queued.
        for (int k = 0; k < 4; k++) begin
            win();
            c_rden = 1'b1; c_radd = 32'h50 + k;
            c_wren = (k < 3); c_wadd = 32'h60 + k; c_idat = k;
            #1 chk($sformatf("rstq_rready%0d", k), {31'd0, c_rready}, 32'd1);
        end
        win();
        rst = 1'b1; c_rden = 1'b1; c_wren = 1'b1; d_rden = 1'b1;
        #1;
        chk("rstq_rready_in_rst", {31'd0, c_rready}, 32'd0);
        chk("rstq_dgnt_in_rst", {31'd0, d_gnt}, 32'd0);
        chk("rstq_wready_in_rst", {31'd0, c_wready}, 32'd0);
        for (int k = 5; k < 10; k++) begin
            win();
            rst = 1'b0; idle_in();
            #1;
            chk($sformatf("rstq_coval%0d", k), {31'd0, c_oval}, 32'd0);
            chk($sformatf("rstq_doval%0d", k), {31'd0, d_oval}, 32'd0);
            chk($sformatf("rstq_mem_enb%0d", k), {31'd0, mem_enb}, 32'd0);
            chk($sformatf("rstq_wready%0d", k), {31'd0, c_wready}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
